// File: rtl/mdu_ctrl.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Latency MULT_CYCLES/DIV_CYCLES; Start is ignored while Busy, the hazard unit stalls on Start|Busy.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_s_q, hi_s_d, lo_s_q, lo_s_d;
    logic        dz_q, dz_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_s, div_u;
    logic        [31:0] quo_s, rem_s, quo_u, rem_u;

    // Divisor is forced to 1 for x/0 and INT_MIN/-1 so the datapath never sees an undefined divide.
    assign div_s = ((In2 == 32'd0) || (In1 == 32'h8000_0000 && In2 == 32'hFFFF_FFFF)) ? 32'd1 : In2;
    assign div_u = (In2 == 32'd0) ? 32'd1 : In2;

    assign a_sx   = {{32{In1[31]}}, In1};
    assign b_sx   = {{32{In2[31]}}, In2};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, In1} * {32'd0, In2};
    assign quo_s  = $signed(In1) / $signed(div_s);
    assign rem_s  = $signed(In1) % $signed(div_s);
    assign quo_u  = In1 / div_u;
    assign rem_u  = In1 % div_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_s_d  = hi_s_q;
        lo_s_d  = lo_s_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT: begin
                            hi_s_d  = prod_s[63:32];
                            lo_s_d  = prod_s[31:0];
                            dz_d    = 1'b0;
                            cnt_d   = 16'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            hi_s_d  = prod_u[63:32];
                            lo_s_d  = prod_u[31:0];
                            dz_d    = 1'b0;
                            cnt_d   = 16'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV: begin
                            hi_s_d  = rem_s;
                            lo_s_d  = quo_s;
                            dz_d    = (In2 == 32'd0);
                            cnt_d   = 16'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIVU: begin
                            hi_s_d  = rem_u;
                            lo_s_d  = quo_u;
                            dz_d    = (In2 == 32'd0);
                            cnt_d   = 16'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = In1;
                        OP_MTLO: lo_d = In1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Start is deliberately not examined here; the in-flight op owns the unit.
                if (cnt_q <= 16'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                    if (!dz_q) begin
                        hi_d = hi_s_q;
                        lo_d = lo_s_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_s_q  <= 32'd0;
            lo_s_q  <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_s_q  <= hi_s_d;
            lo_s_q  <= lo_s_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table plus hand-written reset / ignored-Start / back-to-back sequences.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] In1, In2;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .In1     (In1),
        .In2     (In2),
        .MDUOp   (MDUOp),
        .Start   (Start),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller must be at a falling edge; returns at the falling edge of the first cycle Busy is low.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        Start = 1'b1;
        MDUOp = op;
        In1   = a;
        In2   = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = 4'd0;
        busy_cycles = 0;
        while (Busy && busy_cycles < 64) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          nb;
        logic [31:0] lo_before;

        vecs[0] = '{"mult_neg2x3",   4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{"multu_neg2x3",  4'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{"div_m7_2",      4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"divu_7_2",      4'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10};
        vecs[4] = '{"div_7_m2",      4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[5] = '{"mthi",          4'd5, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111, 32'hFFFF_FFFD, 0};
        vecs[6] = '{"mtlo",          4'd6, 32'h2222_2222, 32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 0};
        vecs[7] = '{"div_by_zero",   4'd3, 32'h0000_0064, 32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 10};
        vecs[8] = '{"start_op_none", 4'd0, 32'h5555_5555, 32'h0000_0009, 32'h1111_1111, 32'h2222_2222, 0};
        vecs[9] = '{"start_op_undef",4'd15,32'h6666_6666, 32'h0000_0009, 32'h1111_1111, 32'h2222_2222, 0};

        reset_n = 1'b0;
        Start   = 1'b0;
        MDUOp   = 4'd0;
        In1     = 32'd0;
        In2     = 32'd0;
        #2;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            chk({vecs[i].name, "_busy"}, 32'(nb), 32'(vecs[i].exp_busy));
            chk({vecs[i].name, "_hi"}, HI, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, LO, vecs[i].exp_lo);
        end

        // Back-to-back: the second Start is driven in the first cycle Busy is low.
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
        chk("b2b_first_busy", 32'(nb), 32'd5);
        chk("b2b_first_hi", HI, 32'hFFFF_FFFE);
        chk("b2b_first_lo", LO, 32'h0000_0001);
        run_op(4'd4, 32'd100, 32'd7, nb);
        chk("b2b_second_busy", 32'(nb), 32'd10);
        chk("b2b_second_hi", HI, 32'd2);
        chk("b2b_second_lo", LO, 32'd14);

        // Start pulses during RUN must be ignored.
        lo_before = LO;
        Start = 1'b1; MDUOp = 4'd1; In1 = 32'd3; In2 = 32'd4;
        @(negedge clk);
        nb = 1;
        Start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        nb++;
        Start = 1'b1; MDUOp = 4'd6; In1 = 32'h0000_DEAD;
        @(negedge clk);
        nb++;
        chk("ign_mtlo_lo", LO, lo_before);
        Start = 1'b1; MDUOp = 4'd3; In1 = 32'd100; In2 = 32'd7;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        while (Busy && nb < 64) begin
            nb++;
            @(negedge clk);
        end
        chk("ign_busy", 32'(nb), 32'd5);
        chk("ign_hi", HI, 32'd0);
        chk("ign_lo", LO, 32'd12);
        repeat (3) @(negedge clk);
        chk("ign_no_late_busy", {31'd0, Busy}, 32'd0);

        // Reset while a MULT is in flight: result must be discarded.
        Start = 1'b1; MDUOp = 4'd1; In1 = 32'd5; In2 = 32'd6;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        chk("midrst_busy_before", {31'd0, Busy}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_after_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_after_hi", HI, 32'd0);
        chk("midrst_after_lo", LO, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits in the EX stage beside the ALU. It accepts one mult/div operation per Start pulse and holds Busy for the architectural latency. It commits results to HI/LO on completion and services MTHI/MTLO/MFHI/MFLO. The hazard unit stalls MDU-class instructions in D while `Start | Busy`.

## Interface
- `MULT_CYCLES`, default 5: cycles Busy stays high for MULT/MULTU.
- `DIV_CYCLES`, default 10: cycles Busy stays high for DIV/DIVU.
- `clk` input, 1 bit: sole clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `In1` input, 32 bits: rs operand.
- `In2` input, 32 bits: rt operand.
- `MDUOp` input, 4 bits: operation code. 0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO; all other codes are treated as none.
- `Start` input, 1 bit: one-cycle qualifier for `MDUOp`, valid in the cycle the instruction is in EX.
- `Busy` output, 1 bit: operation in flight.
- `HI` output, 32 bits: HI register (MFHI source).
- `LO` output, 32 bits: LO register (MFLO source).

## Operation
- State machine: IDLE, RUN.
  - IDLE → RUN on `Start` with a mult/div op.
  - RUN → IDLE when the down-counter reaches 1 at an edge.
- On accept:
  - Capture the op, In1 and In2, and compute the result into staging registers `hi_s`/`lo_s`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Result rules:
  - MULT: 64-bit signed product; HI = [63:32], LO = [31:0].
  - MULTU: the same product, unsigned.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (In2 == 0): the operation still runs its full DIV_CYCLES with Busy high, but HI/LO are left unchanged at commit.
- Commit: at the edge where the counter goes 1→0, load HI/LO from staging and drop Busy.
- MTHI/MTLO in IDLE: HI (or LO) ← In1 at the sampling edge. No Busy, and staging is untouched.
- `Start` while in RUN: ignored, whatever `MDUOp` is. The in-flight operation is unaffected. The hazard unit guarantees this never happens; the bench checks it anyway.
- `Start` with op none or an undefined code: no effect.
- HI/LO change only on commit, MTHI/MTLO, or reset.

## Timing
- Reset (`reset_n` low, asynchronous): State = IDLE, counter = 0, Busy = 0, HI = 0, LO = 0, staging = 0.
  - This takes effect immediately, including mid-operation; the in-flight result is discarded.
  - Release is synchronized by the system; the first accepting edge is the first rising edge with `reset_n` high.
- Let E0 be the edge sampling `Start` with a mult/div op:
  - Busy = 1 from just after E0 until just after E(N), where N = MULT_CYCLES or DIV_CYCLES.
  - Busy is high for exactly N cycles.
  - HI/LO take the new values at E(N), in the same edge Busy falls, so HI/LO are valid in the first cycle Busy is low.
- Back-to-back: a new `Start` may be accepted at E(N+1), i.e. the first cycle Busy is low. There is no idle gap beyond that.
- MTHI/MTLO: HI/LO are updated at the sampling edge and are visible in the next cycle.
- Busy is registered only; there is no combinational path from Start to Busy. The hazard unit ORs `Start` itself.
- HI/LO outputs are registers; they are read combinationally in the same cycle for forwarding.

## Test plan
- Reset mid-operation:
  - Stimulus: MULT accepted, then `reset_n` = 0 two cycles later.
  - Required: Busy drops immediately; HI = LO = 0; no commit afterwards.
- Signed MULT:
  - Stimulus: Start, MDUOp = 0001, In1 = 0xFFFFFFFE (−2), In2 = 0x00000003.
  - Required: Busy high exactly 5 cycles; after the fall HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - Then the same operands as MULTU: HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV sign rules:
  - Stimulus: DIV In1 = 0xFFFFFFF9 (−7), In2 = 2.
  - Required: Busy high exactly 10 cycles; LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
  - Then DIVU 7/2: LO = 3, HI = 1.
- Divide by zero:
  - Stimulus: preload HI = 0x11111111 and LO = 0x22222222 via MTHI/MTLO, then DIV In2 = 0.
  - Required: Busy high 10 cycles; HI/LO unchanged.
- Ignored Start while busy:
  - Stimulus: MULT 3×4, then at the 2nd busy cycle Start with MTLO In1 = 0xDEAD, and at the 3rd busy cycle Start with DIV.
  - Required: both ignored; Busy total is 5 cycles; LO = 12, HI = 0.
- Back-to-back operations:
  - Stimulus: MULTU 0xFFFFFFFF×0xFFFFFFFF, then Start DIVU 100/7 in the first cycle Busy is low.
  - Required after the first: HI = 0xFFFFFFFE, LO = 0x00000001.
  - Required: the second operation is accepted and Busy is high another 10 cycles.
  - Required after the second: LO = 14, HI = 2.
